mem_stage_lsu: RTL and testbench
================================

Name: mem_stage_lsu

Overview:
- Parametrised MEM pipeline stage for the 5-stage CPU, between EX and WB.
- Holds the EX→MEM pipeline register with hold, bubble and flush control.
- Supports variable-latency data SRAM responses through a valid handshake, with a wait FSM and a load buffer.
- Performs byte/halfword load extraction with sign or zero extension.
- Drives the WB bus and the forwarding bus to ID, plus a load-pending flag for ID interlock.

Parameters:
- PC_W, 32, width of the PC field.
- SIDE_W, 65, width of the sideband passthrough (HI/LO result plus flag), carried untouched to WB and ID.
- STALL_W, 6, width of the stall bus.
- MEM_IDX, 3, stall bit that governs this stage.
- FWD_BYPASS, 1: 1 forwards load data in the cycle rvalid arrives; 0 forwards only from the load buffer.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- stall  in  STALL_W  stall bus; bit MEM_IDX=1 holds this stage's register.
- flush  in  1  kills the current MEM entry.
- ex_pc  in  PC_W  instruction PC.
- ex_mem_en  in  1  memory access.
- ex_mem_we  in  1  store (no response expected).
- ex_ld_op  in  3  load type: 000 LW, 001 LB, 010 LBU, 011 LH, 100 LHU.
- ex_addr_lo  in  2  address bits [1:0].
- ex_rf_we  in  1  register write enable.
- ex_rf_waddr  in  5  destination register.
- ex_result  in  32  ALU result.
- ex_side  in  SIDE_W  sideband.
- data_sram_rdata  in  32  load data.
- data_sram_rvalid  in  1  load data valid, one pulse per load.
- wb_pc  out  PC_W  PC to WB.
- wb_rf_we  out  1  register write enable to WB.
- wb_rf_waddr  out  5  destination register to WB.
- wb_rf_wdata  out  32  write data to WB.
- wb_side  out  SIDE_W  sideband to WB.
- fwd_rf_we  out  1  forwarding write enable to ID.
- fwd_rf_waddr  out  5  forwarding destination to ID.
- fwd_rf_wdata  out  32  forwarding data to ID.
- fwd_side  out  SIDE_W  forwarding sideband to ID.
- fwd_pending  out  1  load result not yet available; ID must interlock on fwd_rf_waddr.
- stallreq_mem  out  1  request to stall the pipeline.

Behaviour:
- Reset (async, rst=1): pipeline register cleared to a bubble (all fields 0), FSM in PASS, load buffer cleared, all outputs 0.
- Register update, in priority order at posedge clk:
  - flush: load a bubble.
  - stall[MEM_IDX]=0: load the EX fields.
  - otherwise: hold.
- A registered entry is a load when mem_en=1 and mem_we=0.
- FSM states:
  - PASS: no outstanding load. On register load with a load → WAIT; else stay in PASS.
  - WAIT: if rvalid, capture the extracted data into ld_buf → HAVE; if flush without rvalid → DRAIN; if flush with rvalid → PASS (data dropped).
  - HAVE: data in ld_buf; held while stall[MEM_IDX]=1. On register load → WAIT if the new entry is a load, else PASS. On flush → PASS.
  - DRAIN: bubble in the register, waiting to absorb the orphaned response; rvalid → PASS, data discarded.
- Latency: a 1-cycle SRAM (rvalid in the first MEM cycle) causes zero stall cycles.
- stallreq_mem = (WAIT and not rvalid) or (DRAIN and not rvalid).
- While stallreq_mem=1: wb_rf_we=0 and fwd_rf_we=0.
- fwd_pending = rf_we and state WAIT and (not rvalid, or FWD_BYPASS=0).
- rf_wdata selection:
  - load in HAVE: ld_buf.
  - load in WAIT with rvalid: extracted data_sram_rdata.
  - otherwise: ex_result.
- Load extraction, with b = rdata[8*addr_lo+7 : 8*addr_lo] and h = addr_lo[1] ? rdata[31:16] : rdata[15:0]:
  - LW: rdata.
  - LB: sign-extend b. LBU: zero-extend b.
  - LH: sign-extend h. LHU: zero-extend h.
  - addr_lo[0] is ignored for halfwords (alignment exceptions are raised upstream).
  - Unknown ex_ld_op values are treated as LW.
- Stores: no wait; rf_wdata = ex_result.
- Outputs are combinational from the register, FSM and buffer. wb_side and fwd_side are the registered ex_side.
- Changes on data_sram_rdata outside an rvalid cycle have no effect.
- A spurious rvalid in PASS or HAVE is ignored.

Test Plan:
- LW at 0x100, rvalid in the first MEM cycle with rdata=0x80FF1234 → stallreq_mem stays 0; wb_rf_wdata=0x80FF1234 with wb_rf_we=1 in that cycle.
- Extraction with rdata=0x80FF1234:
  - LB addr_lo=3 → 0xFFFFFF80; LBU addr_lo=3 → 0x00000080.
  - LH addr_lo=2 → 0xFFFF80FF; LHU addr_lo=0 → 0x00001234.
- LW with rvalid 3 cycles after entry → stallreq_mem=1 and fwd_pending=1 for 2 cycles with wb_rf_we=0; then data 0xDEADBEEF appears with stallreq_mem=0.
  - Repeat with FWD_BYPASS=0 → fwd_pending stays 1 through the rvalid cycle.
- Load captured, then stall[3]=1 for 3 cycles while data_sram_rdata toggles → state HAVE; wb_rf_wdata stays equal to the captured value.
- flush in WAIT, rvalid 2 cycles later → DRAIN; stallreq_mem=1 until rvalid; wb_rf_we=0 throughout; next entry is unaffected.
- rst asserted mid-WAIT between clock edges → all outputs 0 immediately; FSM in PASS; a later stray rvalid is ignored.

Source files
------------

// File: rtl/mem_stage_lsu.sv
// mem_stage_lsu: MEM pipeline stage with EX->MEM register, variable-latency load wait FSM, load buffer and load extraction.
//   in : clk, rst (async, active-high), stall[STALL_W], flush, ex_* (EX fields), data_sram_rdata/rvalid
//   out: wb_* (to WB), fwd_* (forwarding to ID), fwd_pending (ID interlock), stallreq_mem
module mem_stage_lsu #(
    parameter int PC_W       = 32,
    parameter int SIDE_W     = 65,
    parameter int STALL_W    = 6,
    parameter int MEM_IDX    = 3,
    parameter bit FWD_BYPASS = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [STALL_W-1:0] stall,
    input  logic               flush,
    input  logic [PC_W-1:0]    ex_pc,
    input  logic               ex_mem_en,
    input  logic               ex_mem_we,
    input  logic [2:0]         ex_ld_op,
    input  logic [1:0]         ex_addr_lo,
    input  logic               ex_rf_we,
    input  logic [4:0]         ex_rf_waddr,
    input  logic [31:0]        ex_result,
    input  logic [SIDE_W-1:0]  ex_side,
    input  logic [31:0]        data_sram_rdata,
    input  logic               data_sram_rvalid,
    output logic [PC_W-1:0]    wb_pc,
    output logic               wb_rf_we,
    output logic [4:0]         wb_rf_waddr,
    output logic [31:0]        wb_rf_wdata,
    output logic [SIDE_W-1:0]  wb_side,
    output logic               fwd_rf_we,
    output logic [4:0]         fwd_rf_waddr,
    output logic [31:0]        fwd_rf_wdata,
    output logic [SIDE_W-1:0]  fwd_side,
    output logic               fwd_pending,
    output logic               stallreq_mem
);
    typedef enum logic [1:0] {PASS, WAIT, HAVE, DRAIN} state_t;
    typedef struct packed {
        logic [PC_W-1:0]   pc;
        logic              mem_en;
        logic              mem_we;
        logic [2:0]        ld_op;
        logic [1:0]        addr_lo;
        logic              rf_we;
        logic [4:0]        rf_waddr;
        logic [31:0]       result;
        logic [SIDE_W-1:0] side;
    } entry_t;

    entry_t      entry_q, entry_d;
    state_t      state_q, state_d, after_load;
    logic [31:0] ld_buf_q, ld_buf_d, ld_data, wdata;
    logic [7:0]  b;
    logic [15:0] h;
    logic        stall_mem, load_en, is_ld, unused_stall;

    assign unused_stall = ^stall;
    assign stall_mem    = stall[MEM_IDX];
    assign load_en      = flush | ~stall_mem;
    assign is_ld        = entry_q.mem_en & ~entry_q.mem_we;
    // State that follows whenever the register takes a new entry this cycle.
    assign after_load   = (!flush && ex_mem_en && !ex_mem_we) ? WAIT : PASS;

    assign b = data_sram_rdata[{entry_q.addr_lo, 3'b000} +: 8];
    assign h = entry_q.addr_lo[1] ? data_sram_rdata[31:16] : data_sram_rdata[15:0];
    assign ld_data = entry_q.ld_op == 3'b001 ? {{24{b[7]}}, b} :
                     entry_q.ld_op == 3'b010 ? {24'b0, b} :
                     entry_q.ld_op == 3'b011 ? {{16{h[15]}}, h} :
                     entry_q.ld_op == 3'b100 ? {16'b0, h} : data_sram_rdata;

    always_comb begin
        entry_d  = entry_q;
        state_d  = state_q;
        ld_buf_d = ld_buf_q;
        if (flush)
            entry_d = '0;
        else if (!stall_mem)
            entry_d = '{pc: ex_pc, mem_en: ex_mem_en, mem_we: ex_mem_we, ld_op: ex_ld_op,
                        addr_lo: ex_addr_lo, rf_we: ex_rf_we, rf_waddr: ex_rf_waddr,
                        result: ex_result, side: ex_side};
        case (state_q)
            PASS, HAVE: if (load_en) state_d = after_load;
            WAIT: begin
                if (data_sram_rvalid && !flush) ld_buf_d = ld_data;
                if (flush)
                    state_d = data_sram_rvalid ? PASS : DRAIN;
                else if (data_sram_rvalid)
                    state_d = load_en ? after_load : HAVE;
            end
            // The response arriving here belongs to the flushed load; a newly
            // accepted load in the same cycle still has to wait for its own.
            DRAIN: if (data_sram_rvalid) state_d = load_en ? after_load : PASS;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            entry_q  <= '0;
            state_q  <= PASS;
            ld_buf_q <= '0;
        end else begin
            entry_q  <= entry_d;
            state_q  <= state_d;
            ld_buf_q <= ld_buf_d;
        end
    end

    assign stallreq_mem = (state_q == WAIT || state_q == DRAIN) && !data_sram_rvalid;
    assign wdata = (is_ld && state_q == HAVE) ? ld_buf_q :
                   (is_ld && state_q == WAIT && data_sram_rvalid) ? ld_data : entry_q.result;
    assign wb_pc        = entry_q.pc;
    assign wb_rf_we     = entry_q.rf_we & ~stallreq_mem;
    assign wb_rf_waddr  = entry_q.rf_waddr;
    assign wb_rf_wdata  = wdata;
    assign wb_side      = entry_q.side;
    assign fwd_rf_we    = entry_q.rf_we & ~stallreq_mem;
    assign fwd_rf_waddr = entry_q.rf_waddr;
    assign fwd_rf_wdata = wdata;
    assign fwd_side     = entry_q.side;
    assign fwd_pending  = entry_q.rf_we && state_q == WAIT && (!data_sram_rvalid || !FWD_BYPASS);
endmodule

// File: tb/tb_mem_stage_lsu.sv
// tb_mem_stage_lsu: scoreboard bench for mem_stage_lsu, two instances (forwarding bypass on and off).
module tb_mem_stage_lsu;
    localparam int MEM = 3;

    typedef struct packed {
        logic [31:0] pc;
        logic        en, we;
        logic [2:0]  op;
        logic [1:0]  lo;
        logic        rfwe;
        logic [4:0]  wa;
        logic [31:0] res;
        logic [64:0] side;
        logic        lit;
        logic [31:0] lit_w;
    } instr_t;

    typedef struct packed {
        logic [31:0] pc;
        logic        rfwe;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [64:0] side;
    } exp_t;

    logic        clk = 0, rst = 1, flush = 0;
    logic [5:0]  stall = 0;
    logic [31:0] ex_pc = 0, ex_result = 0, data_sram_rdata = 0;
    logic        ex_mem_en = 0, ex_mem_we = 0, ex_rf_we = 0, data_sram_rvalid = 0;
    logic [2:0]  ex_ld_op = 0;
    logic [1:0]  ex_addr_lo = 0;
    logic [4:0]  ex_rf_waddr = 0;
    logic [64:0] ex_side = 0;

    logic [31:0] wb_pc [2], wb_rf_wdata [2], fwd_rf_wdata [2];
    logic [4:0]  wb_rf_waddr [2], fwd_rf_waddr [2];
    logic [64:0] wb_side [2], fwd_side [2];
    logic        wb_rf_we [2], fwd_rf_we [2], fwd_pending [2], stallreq_mem [2];

    for (genvar g = 0; g < 2; g++) begin : g_dut
        mem_stage_lsu #(.FWD_BYPASS(g == 0)) dut (
            .clk(clk), .rst(rst), .stall(stall), .flush(flush),
            .ex_pc(ex_pc), .ex_mem_en(ex_mem_en), .ex_mem_we(ex_mem_we), .ex_ld_op(ex_ld_op),
            .ex_addr_lo(ex_addr_lo), .ex_rf_we(ex_rf_we), .ex_rf_waddr(ex_rf_waddr),
            .ex_result(ex_result), .ex_side(ex_side),
            .data_sram_rdata(data_sram_rdata), .data_sram_rvalid(data_sram_rvalid),
            .wb_pc(wb_pc[g]), .wb_rf_we(wb_rf_we[g]), .wb_rf_waddr(wb_rf_waddr[g]),
            .wb_rf_wdata(wb_rf_wdata[g]), .wb_side(wb_side[g]),
            .fwd_rf_we(fwd_rf_we[g]), .fwd_rf_waddr(fwd_rf_waddr[g]), .fwd_rf_wdata(fwd_rf_wdata[g]),
            .fwd_side(fwd_side[g]), .fwd_pending(fwd_pending[g]), .stallreq_mem(stallreq_mem[g])
        );
    end

    always #5 clk = ~clk;

    int   checks = 0, failures = 0;
    exp_t q[$];
    bit   mon_en = 0, sram_pending = 0, resp_live = 0, cur_rfwe = 0, rv_now = 0, exp_stall = 0;
    int   sram_cnt = 0;
    logic [31:0] sram_data = 0;
    instr_t bub = '0;

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Reference load extraction: pick the addressed byte/halfword by arithmetic, then extend.
    function automatic logic [31:0] ext(input logic [31:0] d, input logic [2:0] op, input logic [1:0] lo);
        int bv = int'((d >> (8 * lo)) & 32'hFF);
        int hv = int'((d >> (16 * (lo / 2))) & 32'hFFFF);
        case (op)
            3'd1: return 32'(bv >= 128 ? bv - 256 : bv);
            3'd2: return 32'(bv);
            3'd3: return 32'(hv >= 32768 ? hv - 65536 : hv);
            3'd4: return 32'(hv);
            default: return d;
        endcase
    endfunction

    function automatic instr_t rnd_instr();
        instr_t i;
        int r = $urandom_range(5);
        i.pc = $urandom; i.en = r < 4; i.we = r == 3; i.op = 3'($urandom_range(7));
        i.lo = 2'($urandom); i.rfwe = $urandom_range(3) != 0; i.wa = 5'($urandom);
        i.res = $urandom; i.side = {1'($urandom), $urandom, $urandom}; i.lit = 0; i.lit_w = 0;
        return i;
    endfunction

    function automatic instr_t mk_ld(input logic [31:0] pc, input logic [2:0] op, input logic [1:0] lo, input logic [31:0] w);
        instr_t i = rnd_instr();
        i.pc = pc; i.en = 1; i.we = 0; i.op = op; i.lo = lo; i.rfwe = 1; i.lit = 1; i.lit_w = w;
        return i;
    endfunction

    // One clock of stimulus, entered just after a rising edge. The bench plays
    // pipeline controller (stall) and data SRAM (latency lat, data d per load).
    task automatic cycle(input instr_t i, input bit fl, input bit xs, input int lat, input logic [31:0] d, input bit spur);
        bit acc, ld;
        exp_t e;
        rv_now = sram_pending && sram_cnt == 0;
        data_sram_rvalid = rv_now || (spur && !sram_pending && $urandom_range(7) == 0);
        data_sram_rdata = rv_now ? sram_data : $urandom;
        ex_pc = i.pc; ex_mem_en = i.en; ex_mem_we = i.we; ex_ld_op = i.op; ex_addr_lo = i.lo;
        ex_rf_we = i.rfwe; ex_rf_waddr = i.wa; ex_result = i.res; ex_side = i.side; flush = fl;
        #1;
        exp_stall = sram_pending && !rv_now;
        stall = 6'($urandom);
        stall[MEM] = exp_stall | xs;
        acc = !fl && !stall[MEM];
        ld = i.en && !i.we;
        if (fl) q.push_back('0);
        else if (acc) begin
            e.pc = i.pc; e.rfwe = i.rfwe; e.wa = i.wa; e.side = i.side;
            e.wd = i.lit ? i.lit_w : ld ? ext(d, i.op, i.lo) : i.res;
            q.push_back(e);
        end
        @(posedge clk);
        if (rv_now) sram_pending = 0;
        else if (sram_pending) sram_cnt--;
        if (fl) begin
            resp_live = 0; cur_rfwe = 0;
        end else if (acc) begin
            cur_rfwe = i.rfwe;
            if (ld) begin
                sram_pending = 1; sram_cnt = lat; sram_data = d; resp_live = 1;
            end
        end
        #1;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (mon_en) begin
            for (int k = 0; k < 2; k++) begin
                chk("stallreq_mem", stallreq_mem[k], exp_stall);
                chk("fwd_pending", fwd_pending[k], resp_live && sram_pending && cur_rfwe && (!rv_now || k == 1));
                if (stallreq_mem[k]) chk("we_gated", {wb_rf_we[k], fwd_rf_we[k]}, 0);
                if (!exp_stall && q.size() > 0) begin
                    e = q[0];
                    chk("wb_pc", wb_pc[k], e.pc);
                    chk("wb_rf_we", wb_rf_we[k], e.rfwe);
                    chk("wb_rf_waddr", wb_rf_waddr[k], e.wa);
                    chk("wb_rf_wdata", wb_rf_wdata[k], e.wd);
                    chk("wb_side", wb_side[k], e.side);
                    chk("fwd_bus", {fwd_rf_we[k], fwd_rf_waddr[k], fwd_rf_wdata[k]}, {e.rfwe, e.wa, e.wd});
                    chk("fwd_side", fwd_side[k], e.side);
                end
            end
            if (flush || !stall[MEM]) begin
                if (q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL scoreboard at %0t: got empty queue expected an entry", $time);
                end else e = q.pop_front();
            end
        end
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            chk("reset_bus", {wb_rf_we[k], wb_rf_waddr[k], wb_rf_wdata[k], fwd_rf_we[k], fwd_rf_waddr[k],
                              fwd_rf_wdata[k], fwd_pending[k], stallreq_mem[k]}, 0);
            chk("reset_pc_side", {wb_pc[k], wb_side[k]}, 0);
        end
        rst = 0;
        q.push_back('0);
        mon_en = 1;
        // single-cycle LW: no stall, data visible in its first MEM cycle
        cycle(mk_ld(32'h100, 3'd0, 2'd0, 32'h80FF1234), 0, 0, 0, 32'h80FF1234, 0);
        cycle(mk_ld(32'h104, 3'd1, 2'd3, 32'hFFFFFF80), 0, 0, 0, 32'h80FF1234, 0);
        cycle(mk_ld(32'h108, 3'd2, 2'd3, 32'h00000080), 0, 0, 0, 32'h80FF1234, 0);
        cycle(mk_ld(32'h10C, 3'd3, 2'd2, 32'hFFFF80FF), 0, 0, 0, 32'h80FF1234, 0);
        cycle(mk_ld(32'h110, 3'd4, 2'd0, 32'h00001234), 0, 0, 0, 32'h80FF1234, 0);
        cycle(bub, 0, 0, 0, 0, 0);
        // rvalid in the third MEM cycle
        cycle(mk_ld(32'h114, 3'd0, 2'd0, 32'hDEADBEEF), 0, 0, 2, 32'hDEADBEEF, 0);
        repeat (4) cycle(bub, 0, 0, 0, 0, 0);
        // captured load held by stall while rdata toggles
        cycle(mk_ld(32'h118, 3'd3, 2'd2, 32'h00005A5A), 0, 0, 0, 32'h5A5A0000, 0);
        repeat (3) cycle(bub, 0, 1, 0, 0, 1);
        cycle(bub, 0, 0, 0, 0, 0);
        // flush in WAIT, orphan response drained, then a clean load
        cycle(mk_ld(32'h11C, 3'd0, 2'd0, 32'h11111111), 0, 0, 2, 32'h11111111, 0);
        cycle(bub, 1, 0, 0, 0, 0);
        repeat (3) cycle(mk_ld(32'h120, 3'd0, 2'd0, 32'h12345678), 0, 0, 0, 32'h12345678, 0);
        repeat (2) cycle(bub, 0, 0, 0, 0, 0);
        repeat (600) cycle(rnd_instr(), $urandom_range(15) == 0, $urandom_range(5) == 0,
                           $urandom_range(3), $urandom, 1);
        repeat (6) cycle(bub, 0, 0, 0, 0, 0);
        // async reset in the middle of a wait
        cycle(mk_ld(32'h300, 3'd0, 2'd0, 32'h0), 0, 0, 3, 32'h0, 0);
        mon_en = 0;
        data_sram_rvalid = 0; flush = 0; ex_mem_en = 0; ex_rf_we = 0;
        #1 chk("pre_reset_stall", stallreq_mem[0], 1);
        #1 rst = 1;
        #1;
        for (int k = 0; k < 2; k++) begin
            chk("async_reset_bus", {wb_rf_we[k], wb_rf_waddr[k], wb_rf_wdata[k], fwd_rf_we[k], fwd_rf_waddr[k],
                                    fwd_rf_wdata[k], fwd_pending[k], stallreq_mem[k]}, 0);
            chk("async_reset_pc_side", {wb_pc[k], wb_side[k]}, 0);
        end
        @(posedge clk);
        #1 rst = 0;
        data_sram_rvalid = 1; data_sram_rdata = $urandom; stall = 6'b001000;
        #1;
        chk("stray_rvalid_stall", stallreq_mem[0], 0);
        chk("stray_rvalid_bus", {wb_rf_we[0], wb_rf_wdata[0]}, 0);
        @(posedge clk);
        #1 data_sram_rvalid = 0;
        #1;
        chk("after_stray_stall", {stallreq_mem[0], stallreq_mem[1]}, 0);
        chk("after_stray_pending", {fwd_pending[0], fwd_pending[1]}, 0);
        q.delete();
        q.push_back('0);
        sram_pending = 0; resp_live = 0; cur_rfwe = 0; rv_now = 0; exp_stall = 0;
        mon_en = 1;
        cycle(mk_ld(32'h200, 3'd0, 2'd0, 32'hCAFEF00D), 0, 0, 0, 32'hCAFEF00D, 0);
        repeat (2) cycle(bub, 0, 0, 0, 0, 0);
        @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
